uart_baud_gen_os: RTL and testbench
===================================

// Module: uart_baud_gen_os
// PURPOSE
//  Parametrised baud-tick generator for the UART TX/RX datapaths. Derives an
//  oversampling tick (OSR x baud), a bit tick, a mid-bit tick and a legacy
//  square-wave baud_out from one clock. Supports 7 elaboration-time presets plus
//  a runtime custom divisor, glitch-free divisor switching and RX phase resync.
// PARAMETERS
//  CLK_FREQ  50_000_000  input clock frequency, Hz
//  DIV_W     16          divisor/counter width
//  OSR       16          oversample ticks per bit; even, >=4
//  FRAC_W    4           fractional divisor width (used only with UART_BAUD_FRAC_EN)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  en          in   1       count enable
//  baud_sel    in   3       0..6 = 2400,4800,9600,19200,38400,57600,115200; 7 = custom
//  div_custom  in   DIV_W   custom terminal count N (sel=7)
//  div_frac    in   FRAC_W  fractional increment (ignored without macro)
//  div_load    in   1       1-cycle pulse: capture baud_sel/div_custom/div_frac
//  rx_sync     in   1       1-cycle pulse: restart oversample phase (RX start edge)
//  os_tick     out  1       1-cycle pulse, period N+1 clocks
//  bit_tick    out  1       1-cycle pulse, every OSR os_ticks
//  mid_tick    out  1       1-cycle pulse at mid-bit (os_cnt -> OSR/2)
//  baud_out    out  1       toggles on every bit_tick
//  div_pend    out  1       captured divisor not yet applied
// BEHAVIOUR
//  - Preset N = round(CLK_FREQ/(baud*OSR))-1, computed at elaboration; elaboration
//    error if any preset N exceeds DIV_W bits or is <1. Custom N=0 is used as 1.
//  - Reset: cnt=0, os_cnt=0, frac acc=0, all ticks 0, baud_out=0, div_pend=0,
//    active divisor = 9600 preset.
//  - cnt counts 0..N; on the edge where cnt==N and en=1: cnt<=0, os_tick<=1 next
//    cycle (registered), os_cnt<=os_cnt+1 mod OSR. bit_tick asserted with the
//    os_tick on which os_cnt wraps OSR-1->0; mid_tick with the os_tick on which
//    os_cnt becomes OSR/2. bit_tick/mid_tick always coincide with os_tick.
//  - en=0: cnt, os_cnt, acc, baud_out hold; all ticks 0. Resume from held state.
//  - div_load: shadow captures inputs same cycle, div_pend<=1. Applied (active
//    divisor <= shadow, div_pend<=0) at the next cnt==N terminal edge, or on the
//    next edge immediately if en=0. New divisor governs the following period;
//    current period never truncated. Repeat div_load while pending overwrites shadow.
//  - rx_sync (priority over terminal count and div_load): cnt<=0, os_cnt<=0,
//    acc<=0, ticks 0 that cycle, pending shadow applied; baud_out unchanged.
//    First os_tick then N+1 cycles after the sync edge.
//  - Simultaneous div_load and terminal edge: old shadow (if any) applied, new
//    value captured and remains pending.
// CONFIGURATION
//  UART_BAUD_FRAC_EN defined: at each terminal edge sum=acc+div_frac,
//    acc<=sum[FRAC_W-1:0]; next period terminal count = N+sum[FRAC_W]
//    (one extra clock on carry). Average period N+1+div_frac/2^FRAC_W.
//  Undefined: no accumulator; div_frac ignored; period exactly N+1.
// TESTING
//  1. Reset, en=1, defaults -> os_tick every 326 clks, bit_tick every 5216, baud_out toggles per bit_tick.
//  2. div_load sel=6 mid-period -> current 326-clk period completes, then 27-clk periods; div_pend high until switch.
//  3. sel=7, N=3 -> os_tick every 4 clks, bit_tick every 64, mid_tick 32 clks after bit_tick; N=0 -> period 2.
//  4. rx_sync at arbitrary phase -> no tick that cycle, os_tick 4 clks later, mid_tick after 8 os_ticks (N=3).
//  5. en low 100 clks mid-count -> no ticks, counters frozen; en high resumes remaining count; rst_n low mid-run -> all outputs 0 at once.
//  6. UART_BAUD_FRAC_EN, N=3, div_frac=8 -> os periods alternate 4/5 clks, steady-state bit_tick interval 72 clks.

Source files
------------

// File: rtl/uart_baud_gen_os.sv
// Baud tick generator: oversample, bit and mid-bit ticks plus a square-wave baud_out.
// Optional fractional divisor accumulator enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen_os #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIV_W    = 16,
    parameter int OSR      = 16,
    parameter int FRAC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        baud_sel,
    input  logic [DIV_W-1:0]  div_custom,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              rx_sync,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              baud_out,
    output logic              div_pend
);

    localparam int OS_W = $clog2(OSR);

    function automatic longint calc_n(input longint baud);
        longint d;
        d = baud * longint'(OSR);
        return (longint'(CLK_FREQ) + d / 64'sd2) / d - 64'sd1;
    endfunction

    localparam longint PN0 = calc_n(64'sd2400);
    localparam longint PN1 = calc_n(64'sd4800);
    localparam longint PN2 = calc_n(64'sd9600);
    localparam longint PN3 = calc_n(64'sd19200);
    localparam longint PN4 = calc_n(64'sd38400);
    localparam longint PN5 = calc_n(64'sd57600);
    localparam longint PN6 = calc_n(64'sd115200);
    localparam longint MAX_N = (64'sd1 <<< DIV_W) - 64'sd1;

    // Presets are monotonic in baud rate, so the slowest and fastest bound the rest.
    generate
        if (PN0 > MAX_N || PN6 < 64'sd1 || OSR < 4 || (OSR % 2) != 0) begin : g_cfg_err
            $error("uart_baud_gen_os: preset divisor out of range or bad OSR");
        end
    endgenerate

    localparam logic [DIV_W-1:0] N0 = PN0[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N1 = PN1[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N2 = PN2[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N3 = PN3[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N4 = PN4[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N5 = PN5[DIV_W-1:0];
    localparam logic [DIV_W-1:0] N6 = PN6[DIV_W-1:0];

    logic [DIV_W:0]   cnt_q, cnt_d, limit;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0] n_act_q, n_act_d, n_shd_q, n_shd_d, sel_n;
    logic             pend_q, pend_d, baud_q, baud_d;
    logic             os_tick_q, os_tick_d, bit_tick_q, bit_tick_d, mid_tick_q, mid_tick_d;
    logic             term, os_last, apply, extra;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d, frac_act_q, frac_act_d, frac_shd_q, frac_shd_d;
    logic              extra_q, extra_d;
    logic [FRAC_W:0]   sum;
    assign extra = extra_q;
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign extra       = 1'b0;
`endif

    always_comb begin
        sel_n = N2;
        case (baud_sel)
            3'd0: sel_n = N0;
            3'd1: sel_n = N1;
            3'd2: sel_n = N2;
            3'd3: sel_n = N3;
            3'd4: sel_n = N4;
            3'd5: sel_n = N5;
            3'd6: sel_n = N6;
            default: sel_n = (div_custom == '0) ? DIV_W'(1) : div_custom;
        endcase
    end

    // >= rather than == so a divisor shrunk while idle cannot run the counter past its limit.
    assign limit   = {1'b0, n_act_q} + {{DIV_W{1'b0}}, extra};
    assign term    = en && (cnt_q >= limit);
    assign os_last = (os_cnt_q == OS_W'(OSR - 1));

    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        n_act_d    = n_act_q;
        n_shd_d    = n_shd_q;
        pend_d     = pend_q;
        baud_d     = baud_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        apply      = 1'b0;
`ifdef UART_BAUD_FRAC_EN
        acc_d      = acc_q;
        extra_d    = extra_q;
        frac_act_d = frac_act_q;
        frac_shd_d = frac_shd_q;
        sum        = '0;
`endif
        if (rx_sync) begin
            cnt_d    = '0;
            os_cnt_d = '0;
            apply    = pend_q;
`ifdef UART_BAUD_FRAC_EN
            acc_d    = '0;
            extra_d  = 1'b0;
`endif
        end else if (term) begin
            cnt_d      = '0;
            os_cnt_d   = os_last ? '0 : os_cnt_q + OS_W'(1);
            os_tick_d  = 1'b1;
            bit_tick_d = os_last;
            mid_tick_d = (os_cnt_q == OS_W'(OSR / 2 - 1));
            baud_d     = baud_q ^ os_last;
            apply      = pend_q;
`ifdef UART_BAUD_FRAC_EN
            sum        = {1'b0, acc_q} + {1'b0, frac_act_q};
            acc_d      = sum[FRAC_W-1:0];
            extra_d    = sum[FRAC_W];
`endif
        end else if (en) begin
            cnt_d = cnt_q + (DIV_W + 1)'(1);
        end else begin
            apply = pend_q;
        end

        if (apply) begin
            n_act_d    = n_shd_q;
            pend_d     = 1'b0;
`ifdef UART_BAUD_FRAC_EN
            frac_act_d = frac_shd_q;
`endif
        end
        // A load on the same edge as an apply stays pending for the following terminal.
        if (div_load) begin
            n_shd_d    = sel_n;
            pend_d     = 1'b1;
`ifdef UART_BAUD_FRAC_EN
            frac_shd_d = div_frac;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            n_act_q    <= N2;
            n_shd_q    <= N2;
            pend_q     <= 1'b0;
            baud_q     <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            acc_q      <= '0;
            extra_q    <= 1'b0;
            frac_act_q <= '0;
            frac_shd_q <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            n_act_q    <= n_act_d;
            n_shd_q    <= n_shd_d;
            pend_q     <= pend_d;
            baud_q     <= baud_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
`ifdef UART_BAUD_FRAC_EN
            acc_q      <= acc_d;
            extra_q    <= extra_d;
            frac_act_q <= frac_act_d;
            frac_shd_q <= frac_shd_d;
`endif
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign mid_tick = mid_tick_q;
    assign baud_out = baud_q;
    assign div_pend = pend_q;

endmodule

// File: tb/tb_uart_baud_gen_os.sv
// Directed bench for uart_baud_gen_os: tick spacing, divisor switching, resync, enable, reset.
module tb_uart_baud_gen_os;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  baud_sel = 3'd2;
    logic [15:0] div_custom = 16'd0;
    logic [3:0]  div_frac = 4'd0;
    logic        div_load = 1'b0;
    logic        rx_sync = 1'b0;
    logic        os_tick, bit_tick, mid_tick, baud_out, div_pend;

    int vec = 0;
    int errs = 0;

    uart_baud_gen_os dut (
        .clk(clk), .rst_n(rst_n), .en(en), .baud_sel(baud_sel), .div_custom(div_custom),
        .div_frac(div_frac), .div_load(div_load), .rx_sync(rx_sync), .os_tick(os_tick),
        .bit_tick(bit_tick), .mid_tick(mid_tick), .baud_out(baud_out), .div_pend(div_pend)
    );

    always #5 clk = ~clk;

    // Returns negedges elapsed until the selected tick is seen (0=os,1=bit,2=mid), -1 on timeout.
    task automatic wait_tick(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 6000; i++) begin
            @(negedge clk);
            if ((which == 0 && os_tick) || (which == 1 && bit_tick) || (which == 2 && mid_tick)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({os_tick, bit_tick, mid_tick, baud_out, div_pend} !== 5'b0) begin
            errs++; $display("FAIL reset_outs: got %b want 00000", {os_tick, bit_tick, mid_tick, baud_out, div_pend}); end
        @(negedge clk); rst_n = 1'b1; en = 1'b1;
        wait_tick(0, n);
        vec++; if (n !== 326) begin errs++; $display("FAIL first_os: got %0d want 326", n); end
        wait_tick(0, n);
        vec++; if (n !== 326) begin errs++; $display("FAIL os_period_9600: got %0d want 326", n); end
        wait_tick(1, n);
        vec++; if (n !== 5216 - 652) begin errs++; $display("FAIL first_bit: got %0d want %0d", n, 5216 - 652); end
        vec++; if (baud_out !== 1'b1) begin errs++; $display("FAIL baud_toggle1: got %b want 1", baud_out); end
        wait_tick(1, n);
        vec++; if (n !== 5216) begin errs++; $display("FAIL bit_period_9600: got %0d want 5216", n); end
        vec++; if (baud_out !== 1'b0) begin errs++; $display("FAIL baud_toggle2: got %b want 0", baud_out); end
    endtask

    task automatic test_switch_preset;
        int n;
        baud_sel = 3'd5; div_load = 1'b1;
        @(negedge clk); baud_sel = 3'd6;
        @(negedge clk); div_load = 1'b0;
        vec++; if (div_pend !== 1'b1) begin errs++; $display("FAIL pend_set: got %b want 1", div_pend); end
        wait_tick(0, n);
        vec++; if (n !== 324) begin errs++; $display("FAIL old_period_kept: got %0d want 324", n); end
        vec++; if (div_pend !== 1'b0) begin errs++; $display("FAIL pend_clear: got %b want 0", div_pend); end
        wait_tick(0, n);
        vec++; if (n !== 27) begin errs++; $display("FAIL os_period_115200: got %0d want 27", n); end
        wait_tick(0, n);
        vec++; if (n !== 27) begin errs++; $display("FAIL os_period_115200b: got %0d want 27", n); end
    endtask

    task automatic test_custom;
        int n;
        baud_sel = 3'd7; div_custom = 16'd3; div_load = 1'b1;
        @(negedge clk); div_load = 1'b0;
        wait_tick(0, n);
        vec++; if (n !== 26) begin errs++; $display("FAIL custom_switch: got %0d want 26", n); end
        wait_tick(0, n);
        vec++; if (n !== 4) begin errs++; $display("FAIL os_period_n3: got %0d want 4", n); end
        wait_tick(1, n);
        vec++; if (os_tick !== 1'b1) begin errs++; $display("FAIL bit_with_os: got %b want 1", os_tick); end
        wait_tick(2, n);
        vec++; if (n !== 32) begin errs++; $display("FAIL bit_to_mid: got %0d want 32", n); end
        vec++; if (os_tick !== 1'b1) begin errs++; $display("FAIL mid_with_os: got %b want 1", os_tick); end
        wait_tick(1, n);
        vec++; if (n !== 32) begin errs++; $display("FAIL mid_to_bit: got %0d want 32", n); end
        wait_tick(1, n);
        vec++; if (n !== 64) begin errs++; $display("FAIL bit_period_n3: got %0d want 64", n); end
        div_custom = 16'd0; div_load = 1'b1;
        @(negedge clk); div_load = 1'b0;
        wait_tick(0, n);
        vec++; if (n !== 3) begin errs++; $display("FAIL n0_switch: got %0d want 3", n); end
        wait_tick(0, n);
        vec++; if (n !== 2) begin errs++; $display("FAIL os_period_n0: got %0d want 2", n); end
        wait_tick(0, n);
        vec++; if (n !== 2) begin errs++; $display("FAIL os_period_n0b: got %0d want 2", n); end
    endtask

    task automatic test_rx_sync;
        int n;
        div_custom = 16'd3; div_load = 1'b1;
        @(negedge clk); div_load = 1'b0;
        repeat (5) @(negedge clk);
        rx_sync = 1'b1;
        @(negedge clk); rx_sync = 1'b0;
        vec++; if ({os_tick, bit_tick, mid_tick, div_pend} !== 4'b0) begin
            errs++; $display("FAIL sync_quiet: got %b want 0000", {os_tick, bit_tick, mid_tick, div_pend}); end
        wait_tick(0, n);
        vec++; if (n !== 4) begin errs++; $display("FAIL sync_first_os: got %0d want 4", n); end
        wait_tick(2, n);
        vec++; if (n !== 28) begin errs++; $display("FAIL sync_mid: got %0d want 28", n); end
        wait_tick(1, n);
        vec++; if (n !== 32) begin errs++; $display("FAIL sync_bit: got %0d want 32", n); end
    endtask

    task automatic test_enable_and_async_reset;
        int n, ticks;
        logic b;
        @(negedge clk); en = 1'b0; b = baud_out;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (os_tick || bit_tick || mid_tick) ticks++;
        end
        vec++; if (ticks !== 0) begin errs++; $display("FAIL en_low_ticks: got %0d want 0", ticks); end
        vec++; if (baud_out !== b) begin errs++; $display("FAIL en_low_baud: got %b want %b", baud_out, b); end
        en = 1'b1;
        wait_tick(0, n);
        vec++; if (n !== 3) begin errs++; $display("FAIL en_resume: got %0d want 3", n); end
        wait_tick(2, n);
        vec++; if (n !== 28) begin errs++; $display("FAIL en_resume_mid: got %0d want 28", n); end
        rst_n = 1'b0;
        #1;
        vec++; if ({os_tick, bit_tick, mid_tick, baud_out, div_pend} !== 5'b0) begin
            errs++; $display("FAIL async_reset: got %b want 00000", {os_tick, bit_tick, mid_tick, baud_out, div_pend}); end
    endtask

    task automatic test_idle_load_frac;
        int n;
        int exp_p[4];
`ifdef UART_BAUD_FRAC_EN
        exp_p = '{4, 5, 4, 5};
`else
        exp_p = '{4, 4, 4, 4};
`endif
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; baud_sel = 3'd7; div_custom = 16'd3; div_frac = 4'd8; div_load = 1'b1;
        @(negedge clk); div_load = 1'b0;
        vec++; if (div_pend !== 1'b1) begin errs++; $display("FAIL idle_pend_set: got %b want 1", div_pend); end
        @(negedge clk);
        vec++; if (div_pend !== 1'b0) begin errs++; $display("FAIL idle_apply: got %b want 0", div_pend); end
        rx_sync = 1'b1; en = 1'b1;
        @(negedge clk); rx_sync = 1'b0;
        wait_tick(0, n);
        vec++; if (n !== 4) begin errs++; $display("FAIL frac_first: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            wait_tick(0, n);
            vec++; if (n !== exp_p[i]) begin errs++; $display("FAIL frac_period%0d: got %0d want %0d", i, n, exp_p[i]); end
        end
        wait_tick(1, n);
        wait_tick(1, n);
`ifdef UART_BAUD_FRAC_EN
        vec++; if (n !== 72) begin errs++; $display("FAIL frac_bit: got %0d want 72", n); end
`else
        vec++; if (n !== 64) begin errs++; $display("FAIL frac_bit: got %0d want 64", n); end
`endif
    endtask

    initial begin
        test_reset;
        test_switch_preset;
        test_custom;
        test_rx_sync;
        test_enable_and_async_reset;
        test_idle_load_frac;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
